// File: rtl/lcd_driver_n.sv
// Registered LCD driver: selects key/alarm/current time, converts BCD digits to ASCII,
// blinks the digit under edit, and runs the alarm ring/snooze/stop state machine.
module lcd_driver_n #(
    parameter int NUM_DIGITS    = 4,
    parameter int BLINK_DIV     = 25000000,
    parameter int ALARM_CYCLES  = 50000000,
    parameter int SNOOZE_CYCLES = 300000000
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [4*NUM_DIGITS-1:0]                             alarm_time,
    input  logic [4*NUM_DIGITS-1:0]                             current_time,
    input  logic [4*NUM_DIGITS-1:0]                             key_time,
    input  logic                                                show_a,
    input  logic                                                show_key,
    input  logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] edit_pos,
    input  logic                                                alarm_en,
    input  logic                                                snooze,
    input  logic                                                stop,
    output logic [8*NUM_DIGITS-1:0]                             display,
    output logic                                                sound_a,
    output logic                                                snoozing
);

    localparam int BLINK_W  = $clog2(BLINK_DIV + 1);
    localparam int RING_W   = $clog2(ALARM_CYCLES + 1);
    localparam int SNOOZE_W = $clog2(SNOOZE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    alarm_state_t          state;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blink_phase;
    logic [RING_W-1:0]     ring_cnt;
    logic [SNOOZE_W-1:0]   snooze_cnt;
    logic                  match;
    logic                  match_d;
    logic                  trigger;
    logic [4*NUM_DIGITS-1:0] src_time;
    logic [8*NUM_DIGITS-1:0] display_next;

    function automatic logic [7:0] to_ascii(input logic [3:0] v);
        return (v <= 4'd9) ? (8'h30 + {4'h0, v}) : 8'h45;
    endfunction

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        src_time = current_time;
        if (show_key)
            src_time = key_time;
        else if (show_a)
            src_time = alarm_time;

        display_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (show_key && !blink_phase && (int'(edit_pos) == i))
                display_next[8*i +: 8] = 8'h20;
            else
                display_next[8*i +: 8] = to_ascii(src_time[4*i +: 4]);
        end
    end

    assign match   = alarm_en && (current_time == alarm_time);
    assign trigger = match && !match_d;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            display     <= {NUM_DIGITS{8'h20}};
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            display <= display_next;
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Outputs are assigned together with the state so they track it without a decode stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
            match_d    <= 1'b1;
            sound_a    <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            match_d <= match;
            if (!alarm_en || stop) begin
                state    <= IDLE;
                sound_a  <= 1'b0;
                snoozing <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trigger) begin
                            state    <= RINGING;
                            ring_cnt <= '0;
                            sound_a  <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (snooze) begin
                            state      <= SNOOZE;
                            snooze_cnt <= '0;
                            sound_a    <= 1'b0;
                            snoozing   <= 1'b1;
                        end else if (ring_cnt == RING_W'(ALARM_CYCLES - 1)) begin
                            state   <= IDLE;
                            sound_a <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                    SNOOZE: begin
                        if (snooze_cnt == SNOOZE_W'(SNOOZE_CYCLES - 1)) begin
                            state    <= RINGING;
                            ring_cnt <= '0;
                            sound_a  <= 1'b1;
                            snoozing <= 1'b0;
                        end else begin
                            snooze_cnt <= snooze_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        sound_a  <= 1'b0;
                        snoozing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_driver_n.sv
// Bench for lcd_driver_n: table vectors, hand-written alarm sequences, and random
// stimulus checked every cycle against a cycle-count based reference model.
module tb_lcd_driver_n;

    localparam int ND = 4;
    localparam int BD = 4;
    localparam int AC = 8;
    localparam int SC = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] alarm_time = '0;
    logic [15:0] current_time = '0;
    logic [15:0] key_time = '0;
    logic        show_a = 1'b0;
    logic        show_key = 1'b0;
    logic [1:0]  edit_pos = '0;
    logic        alarm_en = 1'b0;
    logic        snooze = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] display;
    logic        sound_a;
    logic        snoozing;

    int total = 0;
    int bad = 0;

    // Reference model state: edges since reset, alarm mode and cycles left in it.
    int          m_edges;
    int          m_mode;   // 0 idle, 1 ringing, 2 snoozing
    int          m_left;
    bit          m_prev;
    logic [31:0] exp_disp;
    logic        exp_snd;
    logic        exp_snz;

    typedef struct {
        logic [15:0] key;
        logic [15:0] alm;
        logic [15:0] cur;
        logic        sk;
        logic        sa;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    lcd_driver_n #(
        .NUM_DIGITS(ND), .BLINK_DIV(BD), .ALARM_CYCLES(AC), .SNOOZE_CYCLES(SC)
    ) dut (
        .clk(clk), .reset(reset), .alarm_time(alarm_time), .current_time(current_time),
        .key_time(key_time), .show_a(show_a), .show_key(show_key), .edit_pos(edit_pos),
        .alarm_en(alarm_en), .snooze(snooze), .stop(stop), .display(display),
        .sound_a(sound_a), .snoozing(snoozing)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_display(input logic [15:0] k, input logic [15:0] a,
                                                input logic [15:0] c, input logic sk,
                                                input logic sa, input logic [1:0] ep,
                                                input bit visible);
        logic [15:0] s;
        logic [31:0] r;
        s = sk ? k : (sa ? a : c);
        r = '0;
        for (int i = 0; i < ND; i++) begin
            int v;
            v = int'(s[4*i +: 4]);
            r[8*i +: 8] = (v < 10) ? 8'(8'h30 + v) : 8'h45;
            if (sk && !visible && int'(ep) == i)
                r[8*i +: 8] = 8'h20;
        end
        return r;
    endfunction

    function automatic void model_step();
        bit m, trig;
        if (reset) begin
            m_edges  = 0;
            m_mode   = 0;
            m_left   = 0;
            m_prev   = 1'b1;
            exp_disp = 32'h20202020;
        end else begin
            exp_disp = ref_display(key_time, alarm_time, current_time, show_key, show_a,
                                   edit_pos, ((m_edges / BD) % 2) == 0);
            m_edges++;
            m = alarm_en && (current_time == alarm_time);
            trig = m && !m_prev;
            m_prev = m;
            if (!alarm_en || stop) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (trig) begin
                    m_mode = 1;
                    m_left = AC;
                end
            end else if (m_mode == 1) begin
                if (snooze) begin
                    m_mode = 2;
                    m_left = SC;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 1;
                    m_left = AC;
                end
            end
        end
        exp_snd = (m_mode == 1);
        exp_snz = (m_mode == 2);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_display", display, exp_disp);
        check("model_sound_a", 32'(sound_a), 32'(exp_snd));
        check("model_snoozing", 32'(snoozing), 32'(exp_snz));
    endtask

    task automatic run_count(input int n, output int snd_cnt, output int snz_cnt);
        snd_cnt = 0;
        snz_cnt = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (sound_a === 1'b1) snd_cnt++;
            if (snoozing === 1'b1) snz_cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] blink_exp [8];
        int snd_n, snz_n;

        vecs[0] = '{16'h0000, 16'h0000, 16'h2359, 1'b0, 1'b0, 32'h32333539};
        vecs[1] = '{16'h0000, 16'h0000, 16'h23C9, 1'b0, 1'b0, 32'h32334539};
        vecs[2] = '{16'h1111, 16'h0959, 16'h2359, 1'b0, 1'b1, 32'h30393539};
        vecs[3] = '{16'h5555, 16'h1234, 16'h0000, 1'b0, 1'b0, 32'h30303030};
        vecs[4] = '{16'h0000, 16'h0000, 16'hFA09, 1'b0, 1'b0, 32'h45453039};
        vecs[5] = '{16'h8888, 16'h1234, 16'h9999, 1'b0, 1'b1, 32'h31323334};
        blink_exp = '{8'h34, 8'h34, 8'h34, 8'h34, 8'h20, 8'h20, 8'h20, 8'h20};

        // Reset state.
        reset = 1'b1;
        cycle();
        check("reset_display", display, 32'h20202020);
        check("reset_sound_a", 32'(sound_a), 32'd0);
        check("reset_snoozing", 32'(snoozing), 32'd0);
        cycle();
        reset = 1'b0;

        // Key entry with blinking digit 0, then alarm display.
        key_time = 16'h1234;
        alarm_time = 16'h0959;
        show_key = 1'b1;
        show_a = 1'b1;
        edit_pos = 2'd0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("blink_char0", 32'(display[7:0]), 32'(blink_exp[i]));
            check("blink_upper", 32'(display[31:8]), 32'h313233);
        end
        show_key = 1'b0;
        cycle();
        check("show_alarm", display, 32'h30393539);

        // Conversion table.
        show_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            key_time = vecs[i].key;
            alarm_time = vecs[i].alm;
            current_time = vecs[i].cur;
            show_key = vecs[i].sk;
            show_a = vecs[i].sa;
            cycle();
            check($sformatf("vec%0d", i), display, vecs[i].exp);
        end
        show_a = 1'b0;

        // Single ring episode, no re-ring while the match persists.
        do_reset();
        alarm_en = 1'b1;
        alarm_time = 16'h0707;
        current_time = 16'h0706;
        cycle();
        cycle();
        current_time = 16'h0707;
        cycle();
        check("ring_start", 32'(sound_a), 32'd1);
        run_count(19, snd_n, snz_n);
        check("ring_len", 32'(snd_n + 1), 32'd8);
        check("ring_end", 32'(sound_a), 32'd0);

        // Snooze at ring cycle 3.
        current_time = 16'h0706;
        cycle();
        current_time = 16'h0707;
        cycle();
        check("ring2_start", 32'(sound_a), 32'd1);
        cycle();
        cycle();
        cycle();
        snooze = 1'b1;
        cycle();
        snooze = 1'b0;
        check("snooze_sound", 32'(sound_a), 32'd0);
        check("snooze_flag", 32'(snoozing), 32'd1);
        run_count(5, snd_n, snz_n);
        check("snooze_len", 32'(snz_n + 1), 32'd6);
        check("snooze_silent", 32'(snd_n), 32'd0);
        cycle();
        check("rering_start", 32'(sound_a), 32'd1);
        check("rering_flag", 32'(snoozing), 32'd0);
        run_count(7, snd_n, snz_n);
        check("rering_len", 32'(snd_n + 1), 32'd8);
        cycle();
        check("rering_end", 32'(sound_a), 32'd0);

        // Stop wins over snooze; alarm_en drop from SNOOZE.
        current_time = 16'h0706;
        cycle();
        current_time = 16'h0707;
        cycle();
        cycle();
        stop = 1'b1;
        snooze = 1'b1;
        cycle();
        stop = 1'b0;
        snooze = 1'b0;
        check("stop_sound", 32'(sound_a), 32'd0);
        check("stop_snoozing", 32'(snoozing), 32'd0);
        current_time = 16'h0706;
        cycle();
        current_time = 16'h0707;
        cycle();
        snooze = 1'b1;
        cycle();
        snooze = 1'b0;
        check("snz_enter", 32'(snoozing), 32'd1);
        cycle();
        alarm_en = 1'b0;
        cycle();
        check("disarm_snoozing", 32'(snoozing), 32'd0);
        check("disarm_sound", 32'(sound_a), 32'd0);

        // Equal times across reset release must not ring; reset mid-ring clears outputs.
        alarm_en = 1'b1;
        alarm_time = 16'h0000;
        current_time = 16'h0000;
        reset = 1'b1;
        cycle();
        cycle();
        cycle();
        reset = 1'b0;
        run_count(12, snd_n, snz_n);
        check("release_no_ring", 32'(snd_n), 32'd0);
        current_time = 16'h0001;
        cycle();
        current_time = 16'h0000;
        cycle();
        check("pre_reset_ring", 32'(sound_a), 32'd1);
        cycle();
        reset = 1'b1;
        cycle();
        check("midring_reset_sound", 32'(sound_a), 32'd0);
        check("midring_reset_display", display, 32'h20202020);
        reset = 1'b0;

        // Random stimulus against the reference model.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            alarm_time = ($urandom_range(0, 1) == 0) ? 16'h0707 : 16'h1234;
            case ($urandom_range(0, 3))
                0, 1: current_time = alarm_time;
                2: current_time = alarm_time ^ 16'h0001;
                default: current_time = 16'($urandom());
            endcase
            key_time = 16'($urandom());
            show_key = 1'($urandom_range(0, 1));
            show_a = 1'($urandom_range(0, 1));
            edit_pos = 2'($urandom_range(0, 3));
            alarm_en = ($urandom_range(0, 19) != 0);
            snooze = ($urandom_range(0, 9) == 0);
            stop = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
